// File: rtl/muldiv_ctrl.sv
// Iterative unsigned multiply/divide sequencer owning the Hi/Lo pair.
// Ports: clk, reset (sync, active-low), op_valid/op/src_a/src_b in; stall, busy, mf_data, hi_out, lo_out, div_zero out.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_zero
);

  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd3;
  localparam logic [2:0] OP_MTLO  = 3'd4;
  localparam logic [2:0] OP_MFHI  = 3'd5;
  localparam logic [2:0] OP_MFLO  = 3'd6;

  localparam int CW = 6;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic is_div_q, is_div_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic dz_q, dz_d;

  logic hilo_op;
  logic accept;

  assign hilo_op = (op != 3'd0) && (op != 3'd7);
  assign accept  = op_valid && hilo_op
                && (state_q == S_IDLE);
  assign stall   = op_valid && hilo_op
                && (state_q == S_RUN);

  assign busy     = (state_q == S_RUN);
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign div_zero = dz_q;

  always_comb begin
    mf_data = '0;
    if (op_valid && op == OP_MFHI)
      mf_data = hi_q;
    else if (op_valid && op == OP_MFLO)
      mf_data = lo_q;
  end

  // Divide step: partial remainder plus the next
  // dividend bit is WIDTH+1 bits wide.
  logic [WIDTH:0] rem_w;
  logic [WIDTH:0] dv_sub;
  logic dv_ge;
  logic [2*WIDTH-1:0] div_next;

  assign rem_w  = work_q[2*WIDTH-1:WIDTH-1];
  assign dv_ge  = rem_w >= {1'b0, opnd_q};
  assign dv_sub = rem_w - {1'b0, opnd_q};

  always_comb begin
    div_next = '0;
    if (dv_ge)
      div_next = {dv_sub[WIDTH-1:0],
                  work_q[WIDTH-2:0], 1'b1};
    else
      div_next = {rem_w[WIDTH-1:0],
                  work_q[WIDTH-2:0], 1'b0};
  end

  // Multiply step: add multiplicand into the
  // high half when the multiplier LSB is set,
  // then shift right keeping the carry.
  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] mul_add;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_add  = work_q[0] ? {1'b0, opnd_q}
                              : '0;
  assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]}
                  + mul_add;
  assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

  logic [2*WIDTH-1:0] step;
  assign step = is_div_q ? div_next : mul_next;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            op == OP_MULTU: begin
              opnd_d   = src_a;
              work_d   = {{WIDTH{1'b0}}, src_b};
              is_div_d = 1'b0;
              cnt_d    = '0;
              state_d  = S_RUN;
            end
            op == OP_DIVU: begin
              opnd_d   = src_b;
              work_d   = {{WIDTH{1'b0}}, src_a};
              is_div_d = 1'b1;
              dz_d     = (src_b == '0);
              cnt_d    = '0;
              state_d  = S_RUN;
            end
            op == OP_MTHI: hi_d = src_a;
            op == OP_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        work_d = step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          hi_d    = step[2*WIDTH-1:WIDTH];
          lo_d    = step[WIDTH-1:0];
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized bench for muldiv_ctrl against an arithmetic Hi/Lo model.
// Directed cases pin the model with literal results.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        stall, busy, div_zero;
  logic [31:0] mf_data, hi_out, lo_out;

  always #5 clk = ~clk;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op(op),
    .src_a(src_a), .src_b(src_b),
    .stall(stall), .busy(busy),
    .mf_data(mf_data), .hi_out(hi_out),
    .lo_out(lo_out), .div_zero(div_zero)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] p_hi = '0, p_lo = '0;
  bit m_dz = 0;
  int m_left = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: results computed with plain * / %,
  // committed after a 32-edge countdown.
  always @(posedge clk) begin
    logic [63:0] prod;
    chk_en = 1;
    if (!reset) begin
      m_hi = '0; m_lo = '0; m_dz = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end else if (op_valid) begin
      case (op)
        3'd1: begin
          prod = {32'd0, src_a} * {32'd0, src_b};
          p_hi = prod[63:32]; p_lo = prod[31:0];
          m_left = 32;
        end
        3'd2: begin
          m_dz = (src_b == 0);
          if (src_b == 0) begin
            p_lo = 32'hFFFF_FFFF; p_hi = src_a;
          end else begin
            p_lo = src_a / src_b; p_hi = src_a % src_b;
          end
          m_left = 32;
        end
        3'd3: m_hi = src_a;
        3'd4: m_lo = src_a;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    logic hop, eb;
    logic [31:0] emf;
    if (chk_en) begin
      eb  = (m_left > 0);
      hop = op_valid && op != 3'd0 && op != 3'd7;
      emf = '0;
      if (op_valid && op == 3'd5) emf = m_hi;
      if (op_valid && op == 3'd6) emf = m_lo;
      chk("busy", {31'd0, busy}, {31'd0, eb});
      chk("stall", {31'd0, stall}, {31'd0, hop && eb});
      chk("mf_data", mf_data, emf);
      chk("hi_out", hi_out, m_hi);
      chk("lo_out", lo_out, m_lo);
      chk("div_zero", {31'd0, div_zero}, {31'd0, m_dz});
    end
  end

  // Called just after a rising edge; returns at a
  // falling edge with stall low, op still presented.
  task automatic present(input logic [2:0] o,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         output int s);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    s = 0;
    @(negedge clk);
    while (stall && s < 40) begin
      s++;
      @(negedge clk);
    end
    if (s >= 40) chk("stall_timeout", 32'(s), 32'd0);
  endtask

  task automatic accept();
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) chk("busy_timeout", 32'(n), 32'd32);
  endtask

  task automatic sync();
    @(posedge clk); #1;
  endtask

  initial begin
    int s, n;
    logic [2:0] ro;
    logic [31:0] ra, rb;

    reset = 1'b0; op_valid = 1'b1; op = 3'd1;
    src_a = 32'd5; src_b = 32'd6;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    chk("rst_dz", {31'd0, div_zero}, 32'd0);
    op_valid = 1'b0; op = 3'd0;
    sync();
    reset = 1'b1;
    sync();

    present(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s);
    accept();
    wait_idle(n);
    chk("mul_busy_cycles", 32'(n), 32'd32);
    chk("mul_hi", hi_out, 32'hFFFF_FFFE);
    chk("mul_lo", lo_out, 32'h0000_0001);
    sync();

    present(3'd2, 32'd100, 32'd7, s);
    accept();
    present(3'd6, 32'd0, 32'd0, s);
    chk("div_stall_cycles", 32'(s), 32'd32);
    chk("div_mflo", mf_data, 32'd14);
    chk("div_hi", hi_out, 32'd2);
    accept();

    present(3'd2, 32'h1234_5678, 32'd0, s);
    accept();
    wait_idle(n);
    chk("dz_lo", lo_out, 32'hFFFF_FFFF);
    chk("dz_hi", hi_out, 32'h1234_5678);
    chk("dz_flag", {31'd0, div_zero}, 32'd1);
    sync();
    present(3'd2, 32'd10, 32'd2, s);
    accept();
    chk("dz_clear", {31'd0, div_zero}, 32'd0);
    wait_idle(n);
    chk("div10_lo", lo_out, 32'd5);
    chk("div10_hi", hi_out, 32'd0);
    sync();

    present(3'd3, 32'hA5A5_A5A5, 32'd0, s);
    accept();
    present(3'd5, 32'd0, 32'd0, s);
    chk("mfhi_nostall", 32'(s), 32'd0);
    chk("mfhi_data", mf_data, 32'hA5A5_A5A5);
    accept();
    present(3'd4, 32'd1, 32'd0, s);
    accept();
    chk("mtlo_hi", hi_out, 32'hA5A5_A5A5);
    chk("mtlo_lo", lo_out, 32'd1);

    present(3'd1, 32'd6, 32'd7, s);
    accept();
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    sync();
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi_out, 32'd0);
    chk("abort_lo", lo_out, 32'd0);
    sync();
    present(3'd1, 32'd3, 32'd5, s);
    accept();
    wait_idle(n);
    chk("mul35_lo", lo_out, 32'd15);
    chk("mul35_hi", hi_out, 32'd0);
    sync();

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b0;
        sync();
        reset = 1'b1;
      end
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1, 2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0)
        ra = 32'($urandom_range(0, 1000));
      present(ro, ra, rb, s);
      accept();
      repeat ($urandom_range(0, 3)) sync();
    end

    repeat (40) sync();
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

- Multi-cycle multiply/divide sequencer for the pipelined CPU's EX stage.
- Owns the 64-bit Hi/Lo register and runs unsigned multiply and divide iteratively, 32 cycles per op.
- Serves MTHI/MTLO/MFHI/MFLO directly.
- Stalls the pipeline whenever a Hi/Lo op arrives before a running multiply/divide has committed.

## Interface
Parameters:
- `WIDTH`, 32: operand width; Hi/Lo are each `WIDTH` bits, and the iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  rising-edge clock, single clock domain.
- `reset`  in  1  synchronous, active-low; sampled on `clk` rising edge.
- `op_valid`  in  1  EX stage presents an op this cycle.
- `op`  in  3  000 NOP, 001 MULTU, 010 DIVU, 011 MTHI, 100 MTLO, 101 MFHI, 110 MFLO, 111 reserved (treated as NOP).
- `src_a`  in  WIDTH  rs value: multiplicand, dividend, or MTHI/MTLO data.
- `src_b`  in  WIDTH  rt value: multiplier or divisor.
- `stall`  out  1  combinational; pipeline must hold `op`, `src_a` and `src_b` stable while high.
- `busy`  out  1  registered; high while an iteration is in progress.
- `mf_data`  out  WIDTH  combinational; Hi for MFHI, Lo for MFLO, 0 otherwise.
- `hi_out`  out  WIDTH  current Hi register.
- `lo_out`  out  WIDTH  current Lo register.
- `div_zero`  out  1  sticky flag, set by a DIVU with divisor 0.

## Operation
States:
- IDLE and RUN; 6-bit iteration counter `cnt`; internal 64-bit work register and WIDTH-bit operand latch.

Op acceptance:
- An op is accepted on an edge when `op_valid=1`, state=IDLE and op ∉ {NOP, reserved}.

IDLE behaviour:
- MULTU/DIVU: latch operands, clear work register, `cnt`←0, go to RUN.
- DIVU additionally clears `div_zero`; if `src_b=0`, set `div_zero`.
- MTHI: Hi←`src_a` in one cycle; Lo unchanged; no RUN.
- MTLO: Lo←`src_a`; Hi unchanged.
- MFHI/MFLO: `mf_data` valid the same cycle; no state change.

RUN behaviour:
- Performs one iteration per cycle, then `cnt`←`cnt`+1.
- MULTU: unsigned shift-add. On the 32nd iteration, Hi←product[63:32], Lo←product[31:0].
- DIVU: unsigned restoring shift-subtract. On the 32nd iteration, Lo←quotient, Hi←remainder.
- DIVU with divisor 0 still runs 32 cycles and commits Lo=all-ones, Hi=dividend, which is what restoring division naturally produces.
- All arithmetic is zero-extended; no overflow detection.
- On the edge completing iteration 32 (`cnt`=31), Hi/Lo are written, state→IDLE and `busy`→0.

Stall rule:
- `stall` = `op_valid` & (state==RUN) & op ∉ {NOP, reserved}.
- Every Hi/Lo op issued during RUN waits, including MFHI/MFLO, MTHI/MTLO and a back-to-back MULTU/DIVU.
- After commit, a stalled MFHI/MFLO returns the newly committed value.

Reset (`reset=0` at an edge, including mid-RUN):
- Hi=Lo=0, state=IDLE, `cnt`=0, `busy`=0, `div_zero`=0.
- Any in-flight op is abandoned with no partial write.
- Reset has priority over every other event on the same edge.

## Timing
- Accept edge E0 → `busy`=1 after E0.
- Iterations occur on E1..E32; Hi/Lo are visible and `busy`=0 after E32.
- Total: 32 cycles of busy, and results are readable in the cycle following E32.
- `stall` for a stalled op is high through the cycle ending at E32 and low in the cycle after.
- MTHI/MTLO: 1 cycle. A back-to-back MTHI at edge N followed by MFHI in cycle N+1 returns the new value with no stall.
- `hi_out`, `lo_out`, `busy` and `div_zero` are registered. `stall` and `mf_data` are combinational from the inputs and state.
- Reset values: `hi_out`=0, `lo_out`=0, `busy`=0, `div_zero`=0, `stall`=0 (given `op_valid`=0 or IDLE), `mf_data`=0.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `op_valid`=1, op=MULTU → `busy`=0, `stall`=0, `hi_out`=`lo_out`=0, `div_zero`=0.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `busy` high for exactly 32 cycles, then `hi_out`=0xFFFFFFFE and `lo_out`=0x00000001.
- DIVU 100/7, then MFLO presented the next cycle → `stall` high for 32 cycles, then `mf_data`=14; `hi_out`=2.
- DIVU 0x12345678/0 → `lo_out`=0xFFFFFFFF, `hi_out`=0x12345678, `div_zero`=1. A following DIVU 10/2 clears `div_zero` at accept and commits Lo=5, Hi=0.
- MTHI 0xA5A5A5A5, then MFHI next cycle → `mf_data`=0xA5A5A5A5 with `stall`=0. A subsequent MTLO 0x1 leaves `hi_out` unchanged.
- Reset during MULTU 6×7 at iteration 10 → next cycle `busy`=0 and Hi/Lo=0. A following MULTU 3×5 commits Lo=15, Hi=0 after 32 cycles.
